// File: rtl/frame_stream_reader.sv
// Frame downloader: fetches a cropped frame window from SDRAM in fixed bursts
// and streams unpacked pixels, framed by start/row/end markers, into the display queue.
module frame_stream_reader #(
  parameter int ADDR_WIDTH   = 21,
  parameter int DATA_WIDTH   = 32,
  parameter int PIXEL_WIDTH  = 16,
  parameter int BURST_WORDS  = 8,
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272,
  parameter int ROW_STRIDE   = 320
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   queue_full,
  output logic                   queue_wr_en,
  output logic [PIXEL_WIDTH:0]   queue_data,
  output logic                   read_rq,
  output logic [ADDR_WIDTH-1:0]  read_addr,
  input  logic                   read_ack,
  input  logic                   rd_data_valid,
  input  logic [DATA_WIDTH-1:0]  read_data,
  output logic                   busy,
  output logic                   download_done,
  output logic                   download_aborted
);
  localparam int PPW = DATA_WIDTH / PIXEL_WIDTH;
  localparam int WPR = FRAME_WIDTH / PPW;
  localparam int CW  = $clog2(FRAME_WIDTH + 1);
  localparam int RW  = $clog2(FRAME_HEIGHT + 1);
  localparam int BI  = $clog2(BURST_WORDS);
  localparam int BC  = $clog2(BURST_WORDS + 1);
  localparam int PI  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WC  = $clog2(WPR + BURST_WORDS + 1);
  localparam logic [PIXEL_WIDTH:0] M_FSTART = {1'b1, {PIXEL_WIDTH{1'b0}}};
  localparam logic [PIXEL_WIDTH:0] M_RSTART = {1'b1, PIXEL_WIDTH'(1)};
  localparam logic [PIXEL_WIDTH:0] M_FEND   = {1'b1, {PIXEL_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FSTART, S_RSTART, S_REQ, S_RECV, S_DRAIN, S_FEND, S_DONE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_wr_en, r_read_rq, r_busy, r_done, r_aborted, r_abort_pend;
  logic [PIXEL_WIDTH:0]    r_qdata;
  logic [ADDR_WIDTH-1:0]   r_read_addr, r_row_addr, r_burst_addr;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic [WC-1:0]           r_wcol;
  logic [BI-1:0]           r_beat;
  logic [BC-1:0]           r_cnt, r_rd_word;
  logic [PI-1:0]           r_rd_pix;
  logic [DATA_WIDTH-1:0]   r_buf [BURST_WORDS];

  logic                    w_abort, w_keep, w_wr, w_latch, w_row_begin, w_acked, w_store;
  logic                    w_emit, w_next_burst, w_row_end, w_fin_abort, w_fin_done;
  logic [PIXEL_WIDTH:0]    w_wdata;
  logic [PIXEL_WIDTH-1:0]  w_pixel;

  // Abort stays latched once seen so an in-flight burst is still drained from memory.
  assign w_abort = (r_state != S_IDLE) && (abort || r_abort_pend);
  assign w_keep  = (WC'(r_beat) + r_wcol) < WC'(WPR);
  assign w_pixel = r_buf[r_rd_word[BI-1:0]][32'(r_rd_pix) * PIXEL_WIDTH +: PIXEL_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr         = 1'b0;
    w_wdata      = '0;
    w_latch      = 1'b0;
    w_row_begin  = 1'b0;
    w_acked      = 1'b0;
    w_store      = 1'b0;
    w_emit       = 1'b0;
    w_next_burst = 1'b0;
    w_row_end    = 1'b0;
    w_fin_abort  = 1'b0;
    w_fin_done   = 1'b0;
    case (r_state)
      S_IDLE: if (start && !abort) begin
        w_latch = 1'b1; w_state_nxt = S_FSTART;
      end
      S_FSTART: if (w_abort) begin
        w_fin_abort = 1'b1; w_state_nxt = S_IDLE;
      end else if (!queue_full) begin
        w_wr = 1'b1; w_wdata = M_FSTART; w_state_nxt = S_RSTART;
      end
      S_RSTART: if (w_abort) begin
        w_fin_abort = 1'b1; w_state_nxt = S_IDLE;
      end else if (!queue_full) begin
        w_wr = 1'b1; w_wdata = M_RSTART; w_row_begin = 1'b1; w_state_nxt = S_REQ;
      end
      S_REQ: if (read_ack) begin
        w_acked = 1'b1; w_state_nxt = S_RECV;
      end
      S_RECV: if (rd_data_valid) begin
        w_store = 1'b1;
        if (r_beat == BI'(BURST_WORDS - 1)) begin
          w_fin_abort = w_abort;
          w_state_nxt = w_abort ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: if (w_abort) begin
        w_fin_abort = 1'b1; w_state_nxt = S_IDLE;
      end else if (r_rd_word == r_cnt) begin
        if (r_col == CW'(FRAME_WIDTH)) begin
          w_row_end   = 1'b1;
          w_state_nxt = (r_row == RW'(FRAME_HEIGHT - 1)) ? S_FEND : S_RSTART;
        end else begin
          w_next_burst = 1'b1; w_state_nxt = S_REQ;
        end
      end else if (!queue_full) begin
        w_wr = 1'b1; w_wdata = {1'b0, w_pixel}; w_emit = 1'b1;
      end
      S_FEND: if (w_abort) begin
        w_fin_abort = 1'b1; w_state_nxt = S_IDLE;
      end else if (!queue_full) begin
        w_wr = 1'b1; w_wdata = M_FEND; w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_fin_done = 1'b1; w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en <= 1'b0; r_qdata <= '0; r_read_rq <= 1'b0; r_read_addr <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_aborted <= 1'b0; r_abort_pend <= 1'b0;
      r_row_addr <= '0; r_burst_addr <= '0; r_row <= '0; r_col <= '0; r_wcol <= '0;
      r_beat <= '0; r_cnt <= '0; r_rd_word <= '0; r_rd_pix <= '0;
    end else begin
      r_wr_en   <= w_wr;
      r_done    <= w_fin_done;
      r_aborted <= w_fin_abort;
      if (w_wr) r_qdata <= w_wdata;
      if (w_latch) begin
        r_busy <= 1'b1; r_row_addr <= base_addr; r_row <= '0;
      end else if (w_fin_abort || w_fin_done) begin
        r_busy <= 1'b0;
      end
      if (w_fin_abort || w_fin_done) r_abort_pend <= 1'b0;
      else if (r_busy && abort)      r_abort_pend <= 1'b1;
      if (w_row_begin) begin
        r_col <= '0; r_wcol <= '0; r_burst_addr <= r_row_addr;
        r_read_addr <= r_row_addr; r_read_rq <= 1'b1;
      end else if (w_next_burst) begin
        r_burst_addr <= r_burst_addr + ADDR_WIDTH'(BURST_WORDS);
        r_read_addr  <= r_burst_addr + ADDR_WIDTH'(BURST_WORDS);
        r_wcol       <= r_wcol + WC'(BURST_WORDS);
        r_read_rq    <= 1'b1;
      end else if (w_acked) begin
        r_read_rq <= 1'b0; r_beat <= '0; r_cnt <= '0; r_rd_word <= '0; r_rd_pix <= '0;
      end
      // Beats past the end of the row advance the beat count but are not buffered.
      if (w_store) begin
        r_beat <= r_beat + BI'(1);
        if (w_keep) r_cnt <= r_cnt + BC'(1);
      end
      if (w_emit) begin
        r_col <= r_col + CW'(1);
        if (r_rd_pix == PI'(PPW - 1)) begin
          r_rd_pix <= '0; r_rd_word <= r_rd_word + BC'(1);
        end else begin
          r_rd_pix <= r_rd_pix + PI'(1);
        end
      end
      if (w_row_end) begin
        r_row <= r_row + RW'(1); r_row_addr <= r_row_addr + ADDR_WIDTH'(ROW_STRIDE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store && w_keep) r_buf[r_beat] <= read_data;
  end

  assign queue_wr_en      = r_wr_en;
  assign queue_data       = r_qdata;
  assign read_rq          = r_read_rq;
  assign read_addr        = r_read_addr;
  assign busy             = r_busy;
  assign download_done    = r_done;
  assign download_aborted = r_aborted;
endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
- Next-generation frame downloader. Reads a stored frame from SDRAM in fixed-length bursts and unpacks each memory word into pixels.
- Streams pixels into the display pixel queue, framed by frame-start, row-start and frame-end markers.
- Generalised over data/pixel width, burst length and row stride (cropped window out of a larger stored frame). Adds abort, busy and burst-tail discard.

Parameters:
- ADDR_WIDTH, 21, memory word address width.
- DATA_WIDTH, 32, memory read data width.
- PIXEL_WIDTH, 16, pixel width; DATA_WIDTH must be an integer multiple; PPW = DATA_WIDTH/PIXEL_WIDTH.
- BURST_WORDS, 8, words returned per read request; power of 2, 2..32.
- FRAME_WIDTH, 480, output pixels per row; must be a multiple of PPW.
- FRAME_HEIGHT, 272, output rows per frame.
- ROW_STRIDE, 320, word-address distance between consecutive stored rows; must be >= FRAME_WIDTH/PPW.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE
- abort  in  1  cancel current frame; level, sampled every cycle
- base_addr  in  ADDR_WIDTH  word address of pixel (0,0); latched on accepted start
- queue_full  in  1  pixel queue cannot take 2 more entries
- queue_wr_en  out  1  queue write strobe
- queue_data  out  PIXEL_WIDTH+1  MSB=1 marker, MSB=0 pixel
- read_rq  out  1  burst read request
- read_addr  out  ADDR_WIDTH  burst start address, stable while read_rq high
- read_ack  in  1  memory accepted request (one cycle)
- rd_data_valid  in  1  read beat valid
- read_data  in  DATA_WIDTH  read beat
- busy  out  1  frame in progress
- download_done  out  1  one-cycle pulse, frame completed
- download_aborted  out  1  one-cycle pulse, frame aborted

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-high.
- Reset state: FSM IDLE. All outputs, row/column/address counters and the burst buffer valid count are 0.
- Markers: FSTART = {1, 0x0000}, RSTART = {1, 0x0001}, FEND = {1, all ones}. Pixels = {0, pixel}.
- Word unpacking: least-significant pixel is emitted first.
- Queue rule: queue_wr_en and queue_data are registered. A write is issued only if queue_full was sampled low in the issuing cycle. queue_wr_en is high for exactly one cycle per item. Back-to-back writes are allowed.
- State IDLE:
  - start=1 latches base_addr into row_addr, sets busy=1, goes to FSTART.
  - start is ignored while busy.
- State FSTART: write FSTART (waiting while queue_full is high), then go to RSTART.
- State RSTART: write RSTART (waiting while queue_full is high), set col=0 and burst_addr=row_addr, then go to REQ.
- State REQ:
  - read_rq=1, read_addr=burst_addr.
  - On read_ack: read_rq=0 on the next cycle, go to RECV.
- State RECV:
  - Accept exactly BURST_WORDS beats on rd_data_valid into the internal buffer (BURST_WORDS x DATA_WIDTH). Gaps between beats are allowed; memory cannot be stalled.
  - Beats beyond the words still needed in the row are counted and discarded (tail discard).
  - After the last beat, go to DRAIN.
- State DRAIN:
  - Emit the buffered pixels in order; col increments per pixel.
  - Buffer empty and col < FRAME_WIDTH: burst_addr += BURST_WORDS, go to REQ.
  - col == FRAME_WIDTH: row += 1, row_addr += ROW_STRIDE. If row == FRAME_HEIGHT go to FEND, else go to RSTART.
- State FEND: write FEND. The cycle after that write, pulse download_done, drop busy, return to IDLE.
- Bursts per row: ceil(FRAME_WIDTH/PPW/BURST_WORDS). Address arithmetic wraps modulo 2^ADDR_WIDTH.
- abort=1 while busy:
  - No further queue writes.
  - If a request is acknowledged, or beats are outstanding, consume all remaining beats of that burst first.
  - If in REQ before ack, keep read_rq high until ack, then consume the burst.
  - Then pulse download_aborted, drop busy, return to IDLE. No FEND is written.
  - abort in IDLE is ignored.
- start and abort in the same IDLE cycle: start is ignored.
- Reset mid-burst: immediate return to IDLE. The memory controller is reset on the same signal.

Test Plan:
- FRAME_WIDTH=8, FRAME_HEIGHT=2, BURST_WORDS=4, ROW_STRIDE=10, base 0x100, words = address -> two requests at 0x100 and 0x10A. Queue receives exactly 20 entries: FSTART, RSTART, 8 pixels, RSTART, 8 pixels, FEND. Pixels of word 0x100 appear as 0x0100 then 0x0000. One download_done pulse.
- FRAME_WIDTH=12, BURST_WORDS=4 -> per row, requests at base and base+4. The second burst's last 2 words are discarded: 12 pixels per row, none from base+6/base+7.
- queue_full held high 50 cycles in mid-row -> no queue_wr_en while high, no pixel lost or duplicated, order preserved.
- abort asserted 2 beats into a burst -> remaining 2 beats consumed, download_aborted pulses once, no FEND, next start works normally.
- Second start pulse while busy -> ignored, only one FSTART. Reset asserted during RECV -> all outputs 0 next cycle.
- rd_data_valid with random gaps -> pixel stream identical to the gap-free run.
